// File: rtl/biquad_pkg.sv
// Shared FSM encoding, coefficient indices, op select and reduction helpers
// for the time-multiplexed biquad cascade.
package biquad_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam int IDX_A1 = 0;
  localparam int IDX_A2 = 1;
  localparam int IDX_B0 = 2;
  localparam int IDX_B1 = 3;
  localparam int IDX_B2 = 4;
  localparam int COEFS_PER_SECTION = 5;

  typedef enum logic {
    OP_LOAD = 1'b0,
    OP_ACC  = 1'b1
  } mac_op_e;

  // Pass-through section: b0 = 1.0, everything else 0.
  function automatic logic signed [63:0] identity_coef(input int idx, input int frac_w);
    return (idx == IDX_B0) ? (64'sd1 <<< frac_w) : 64'sd0;
  endfunction

  function automatic int acc_width(input int data_w, input int coef_w);
    return data_w + coef_w + 3;
  endfunction

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/biquad_cascade_tdm_if.sv
// Sample handshake, coefficient write bus and status flags of biquad_cascade_tdm.
interface biquad_cascade_tdm_if #(
  parameter int DATA_W = 18,
  parameter int COEF_W = 18,
  parameter int ADDR_W = 5
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     coef_we;
  logic [ADDR_W-1:0]        coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;
  logic                     coef_wr_drop;
  logic                     state_clr;
  logic                     sat_flag;

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_wdata, state_clr,
    input  in_ready, out_valid, out_data, coef_wr_drop, sat_flag
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_wdata, state_clr,
    output in_ready, out_valid, out_data, coef_wr_drop, sat_flag
  );
endinterface

// File: rtl/biquad_mac.sv
// Shared multiply-accumulate with floor shift and DATA_W reduction.
// BIQUAD_SAT_EN selects clamping (reported on clamp_o) instead of two's-complement wrap.
module biquad_mac
  import biquad_pkg::*;
#(
  parameter int DATA_W = 18,
  parameter int COEF_W = 18,
  parameter int FRAC_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  mac_op_e                  op_i,
  input  logic signed [DATA_W-1:0] add_i,
  input  logic signed [DATA_W-1:0] mul_a_i,
  input  logic signed [COEF_W-1:0] mul_b_i,
  output logic signed [DATA_W-1:0] red_o
`ifdef BIQUAD_SAT_EN
  ,
  output logic                     clamp_o
`endif
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = acc_width(DATA_W, COEF_W);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_q;

  always_comb begin
    prod  = PROD_W'(mul_a_i) * PROD_W'(mul_b_i);
    base  = (op_i == OP_LOAD) ? (ACC_W'(add_i) <<< FRAC_W) : acc_q;
    acc_d = base + ACC_W'(prod);
  end

`ifdef BIQUAD_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(DATA_W));
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(DATA_W));
  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = acc_d >>> FRAC_W;
    clamp_o = 1'b0;
    red_o   = shifted[DATA_W-1:0];
    if (shifted > MAX_V) begin
      red_o   = MAX_V[DATA_W-1:0];
      clamp_o = 1'b1;
    end else if (shifted < MIN_V) begin
      red_o   = MIN_V[DATA_W-1:0];
      clamp_o = 1'b1;
    end
  end
`else
  // Floor shift followed by wrap is just a slice of the accumulator.
  assign red_o = acc_d[FRAC_W +: DATA_W];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end
endmodule

// File: rtl/biquad_cascade_tdm.sv
// Cascade of NUM_SECTIONS direct-form-II biquads time-multiplexed over one MAC.
// Define BIQUAD_SAT_EN for saturating reduction and a sticky sat_flag.
module biquad_cascade_tdm
  import biquad_pkg::*;
#(
  parameter int DATA_W       = 18,
  parameter int COEF_W       = 18,
  parameter int FRAC_W       = 16,
  parameter int NUM_SECTIONS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  biquad_cascade_tdm_if.slave  bus
);
  localparam int NUM_COEF = COEFS_PER_SECTION * NUM_SECTIONS;
  localparam int ADDR_W   = $clog2(NUM_COEF);
  localparam int SEC_W    = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;

  logic [1:0]               state_q, state_d;
  logic [2:0]               step_q;
  logic [SEC_W-1:0]         sec_q;
  logic signed [DATA_W-1:0] x_q, w_reg_q, out_data_q;
  logic                     out_valid_q, drop_q;

  logic signed [COEF_W-1:0] coef_all [NUM_COEF];
  logic signed [DATA_W-1:0] w1_all [NUM_SECTIONS];
  logic signed [DATA_W-1:0] w2_all [NUM_SECTIONS];

  logic idle, accept, clr_go, wr_go, shift_go, last_sec;
  logic [ADDR_W-1:0]        sec_base, rd_addr;
  logic [2:0]               rd_idx;
  mac_op_e                  mac_op;
  logic signed [DATA_W-1:0] mac_add, mac_a, mac_red;
  logic signed [COEF_W-1:0] mac_b;

  assign idle     = (state_q == ST_IDLE);
  assign accept   = idle && !bus.state_clr && bus.in_valid;
  assign clr_go   = idle && bus.state_clr;
  assign wr_go    = idle && bus.coef_we &&
                    ({1'b0, bus.coef_addr} < (ADDR_W + 1)'(NUM_COEF));
  assign shift_go = (state_q == ST_MAC) && (step_q == 3'd4);
  assign last_sec = (sec_q == SEC_W'(NUM_SECTIONS - 1));

  for (genvar gi = 0; gi < NUM_COEF; gi++) begin : g_coef
    localparam logic signed [COEF_W-1:0] RST_V =
      COEF_W'(identity_coef(gi % COEFS_PER_SECTION, FRAC_W));
    logic signed [COEF_W-1:0] coef_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        coef_q <= RST_V;
      end else if (wr_go && (bus.coef_addr == ADDR_W'(gi))) begin
        coef_q <= bus.coef_wdata;
      end
    end
    assign coef_all[gi] = coef_q;
  end

  for (genvar gi = 0; gi < NUM_SECTIONS; gi++) begin : g_sec
    logic signed [DATA_W-1:0] w1_q, w2_q;
    always_ff @(posedge clk) begin
      if (rst || clr_go) begin
        w1_q <= '0;
        w2_q <= '0;
      end else if (shift_go && (sec_q == SEC_W'(gi))) begin
        w2_q <= w1_q;
        w1_q <= w_reg_q;
      end
    end
    assign w1_all[gi] = w1_q;
    assign w2_all[gi] = w2_q;
  end

  // Step schedule: a1*w1, a2*w2, b1*w1, b2*w2, b0*w; w is captured after step 1.
  always_comb begin
    mac_op  = OP_ACC;
    mac_add = x_q;
    mac_a   = w1_all[sec_q];
    rd_idx  = 3'(IDX_A1);
    case (step_q)
      3'd0: begin mac_op = OP_LOAD; mac_a = w1_all[sec_q]; rd_idx = 3'(IDX_A1); end
      3'd1: begin mac_a = w2_all[sec_q]; rd_idx = 3'(IDX_A2); end
      3'd2: begin mac_op = OP_LOAD; mac_add = '0; mac_a = w1_all[sec_q]; rd_idx = 3'(IDX_B1); end
      3'd3: begin mac_a = w2_all[sec_q]; rd_idx = 3'(IDX_B2); end
      default: begin mac_a = w_reg_q; rd_idx = 3'(IDX_B0); end
    endcase
    sec_base = ADDR_W'(sec_q) * ADDR_W'(COEFS_PER_SECTION);
    rd_addr  = sec_base + ADDR_W'(rd_idx);
    mac_b    = coef_all[rd_addr];
  end

`ifdef BIQUAD_SAT_EN
  logic mac_clamp, sat_q;
`endif

  biquad_mac #(.DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_W(FRAC_W)) u_mac (
    .clk     (clk),
    .rst     (rst),
    .en_i    (state_q == ST_MAC),
    .op_i    (mac_op),
    .add_i   (mac_add),
    .mul_a_i (mac_a),
    .mul_b_i (mac_b),
    .red_o   (mac_red)
`ifdef BIQUAD_SAT_EN
    ,
    .clamp_o (mac_clamp)
`endif
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_MAC;
      ST_MAC:  if (shift_go && last_sec) state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      sec_q       <= '0;
      x_q         <= '0;
      w_reg_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_q == ST_OUT);
      drop_q      <= bus.coef_we && !wr_go;
      if (accept) begin
        x_q    <= bus.in_data;
        sec_q  <= '0;
        step_q <= '0;
      end
      if (state_q == ST_MAC) begin
        if (step_q == 3'd1) w_reg_q <= mac_red;
        if (shift_go) begin
          x_q    <= mac_red;
          step_q <= '0;
          if (!last_sec) sec_q <= sec_q + SEC_W'(1);
        end else begin
          step_q <= step_q + 3'd1;
        end
      end
      if (state_q == ST_OUT) out_data_q <= x_q;
    end
  end

`ifdef BIQUAD_SAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if ((state_q == ST_MAC) && ((step_q == 3'd1) || shift_go) && mac_clamp) begin
      sat_q <= 1'b1;
    end
  end
  assign bus.sat_flag = sat_q;
`else
  assign bus.sat_flag = 1'b0;
`endif

  assign bus.in_ready     = idle && !bus.state_clr;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.coef_wr_drop = drop_q;
endmodule

// File: tb/tb_biquad_cascade_tdm.sv
// Directed self-checking bench for biquad_cascade_tdm at default parameters.
module tb_biquad_cascade_tdm;
  localparam int DATA_W       = 18;
  localparam int COEF_W       = 18;
  localparam int FRAC_W       = 16;
  localparam int NUM_SECTIONS = 4;
  localparam int ADDR_W       = $clog2(5 * NUM_SECTIONS);
  localparam int LAT          = 5 * NUM_SECTIONS + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  biquad_cascade_tdm_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ADDR_W(ADDR_W)) bus ();

  biquad_cascade_tdm #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_W(FRAC_W), .NUM_SECTIONS(NUM_SECTIONS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int addr, input int data, output logic drop);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = ADDR_W'(addr);
    bus.coef_wdata = COEF_W'(data);
    tick();
    bus.coef_we = 1'b0;
    drop = bus.coef_wr_drop;
    $display("write addr=%0d data=%0d drop=%0b", addr, data, drop);
  endtask

  task automatic pulse_clear();
    bus.state_clr = 1'b1;
    tick();
    bus.state_clr = 1'b0;
  endtask

  // Offers one sample, returns the result, the latency from the accepting edge
  // and how many busy cycles showed in_ready high (0 when lat stays 0 = timeout).
  task automatic send_sample(input int x, output int y, output int lat, output int busy_rdy,
                             output logic rdy_at_out);
    lat = 0; y = 0; busy_rdy = 0; rdy_at_out = 1'b0;
    for (int k = 0; k < 50 && !bus.in_ready; k++) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = DATA_W'(x);
    tick();
    bus.in_valid = 1'b0;
    if (bus.in_ready) busy_rdy++;
    for (int c = 1; c <= LAT + 20; c++) begin
      tick();
      if (bus.out_valid) begin
        lat = c;
        y = int'(bus.out_data);
        rdy_at_out = bus.in_ready;
        break;
      end
      if (bus.in_ready) busy_rdy++;
    end
    $display("sample in=%0d out=%0d latency=%0d", x, y, lat);
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.coef_we = 1'b0;
    bus.coef_addr = '0; bus.coef_wdata = '0; bus.state_clr = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.coef_wr_drop !== 1'b0 ||
        bus.sat_flag !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b data=%0d drop=%b sat=%b, expected all 0",
               bus.out_valid, bus.out_data, bus.coef_wr_drop, bus.sat_flag);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 1", bus.in_ready);
    end
    $display("reset done ready=%b", bus.in_ready);
  endtask

  task automatic test_identity();
    int y, lat, br;
    logic ro;
    send_sample(1000, y, lat, br, ro);
    checks++;
    if (lat !== LAT) begin
      failures++;
      $display("FAIL identity_latency: got %0d expected %0d", lat, LAT);
    end
    checks++;
    if (y !== 1000) begin
      failures++;
      $display("FAIL identity_data: got %0d expected 1000", y);
    end
    checks++;
    if (br !== 0) begin
      failures++;
      $display("FAIL identity_busy_ready: got %0d busy cycles with in_ready high expected 0", br);
    end
    checks++;
    if (ro !== 1'b1) begin
      failures++;
      $display("FAIL identity_ready_at_out: got %b expected 1", ro);
    end
  endtask

  task automatic test_scaling();
    int y, lat, br;
    logic ro, d;
    write_coef(2, 32768, d);
    checks++;
    if (d !== 1'b0) begin
      failures++;
      $display("FAIL scale_write_drop: got %b expected 0", d);
    end
    send_sample(1000, y, lat, br, ro);
    checks++;
    if (y !== 500) begin
      failures++;
      $display("FAIL scale_pos: got %0d expected 500", y);
    end
    send_sample(-1001, y, lat, br, ro);
    checks++;
    if (y !== -501) begin
      failures++;
      $display("FAIL scale_neg_floor: got %0d expected -501", y);
    end
    write_coef(2, 65536, d);
  endtask

  task automatic test_recursion();
    int exp_v[6] = '{1000, 500, 250, 125, 62, 31};
    int y, lat, br;
    logic ro, d;
    write_coef(0, 32768, d);
    pulse_clear();
    for (int i = 0; i < 6; i++) begin
      send_sample((i == 0) ? 1000 : 0, y, lat, br, ro);
      checks++;
      if (y !== exp_v[i]) begin
        failures++;
        $display("FAIL recursion_%0d: got %0d expected %0d", i, y, exp_v[i]);
      end
    end
    // Clear wins over a same-cycle sample: nothing may be accepted.
    bus.state_clr = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = DATA_W'(777);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL clear_blocks_ready: got %b expected 0", bus.in_ready);
    end
    tick();
    bus.state_clr = 1'b0;
    bus.in_valid  = 1'b0;
    br = 0;
    for (int c = 0; c < LAT + 3; c++) begin
      tick();
      if (bus.out_valid) br++;
    end
    checks++;
    if (br !== 0) begin
      failures++;
      $display("FAIL clear_no_accept: got %0d outputs expected 0", br);
    end
    send_sample(0, y, lat, br, ro);
    checks++;
    if (y !== 0) begin
      failures++;
      $display("FAIL clear_zero_out: got %0d expected 0", y);
    end
    write_coef(0, 0, d);
  endtask

  task automatic test_overflow();
    int y, lat, br, exp_y;
    logic ro, d, exp_sat;
`ifdef BIQUAD_SAT_EN
    exp_y = 131071; exp_sat = 1'b1;
`else
    exp_y = -4; exp_sat = 1'b0;
`endif
    pulse_clear();
    write_coef(2, 131071, d);
    send_sample(131071, y, lat, br, ro);
    checks++;
    if (y !== exp_y) begin
      failures++;
      $display("FAIL overflow_data: got %0d expected %0d", y, exp_y);
    end
    checks++;
    if (bus.sat_flag !== exp_sat) begin
      failures++;
      $display("FAIL overflow_flag: got %b expected %b", bus.sat_flag, exp_sat);
    end
    write_coef(2, 65536, d);
    send_sample(1000, y, lat, br, ro);
    checks++;
    if (y !== 1000 || bus.sat_flag !== exp_sat) begin
      failures++;
      $display("FAIL overflow_sticky: got data=%0d sat=%b expected data=1000 sat=%b",
               y, bus.sat_flag, exp_sat);
    end
  endtask

  task automatic test_write_guard();
    int y, lat, br;
    logic ro, d;
    bus.in_valid = 1'b1;
    bus.in_data  = DATA_W'(1000);
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    write_coef(2, 0, d);
    checks++;
    if (d !== 1'b1) begin
      failures++;
      $display("FAIL guard_busy_drop: got %b expected 1", d);
    end
    tick();
    checks++;
    if (bus.coef_wr_drop !== 1'b0) begin
      failures++;
      $display("FAIL guard_drop_pulse: got %b expected 0 one cycle later", bus.coef_wr_drop);
    end
    y = 0; lat = 0;
    for (int c = 0; c < LAT + 10; c++) begin
      tick();
      if (bus.out_valid) begin
        y = int'(bus.out_data);
        lat = 1;
        break;
      end
    end
    checks++;
    if (lat !== 1 || y !== 1000) begin
      failures++;
      $display("FAIL guard_busy_out: got seen=%0d data=%0d expected seen=1 data=1000", lat, y);
    end
    write_coef(20, 0, d);
    checks++;
    if (d !== 1'b1) begin
      failures++;
      $display("FAIL guard_addr_drop: got %b expected 1", d);
    end
    send_sample(1000, y, lat, br, ro);
    checks++;
    if (y !== 1000) begin
      failures++;
      $display("FAIL guard_identity: got %0d expected 1000", y);
    end
  endtask

  task automatic test_reset_mid();
    int y, lat, br;
    logic ro, d;
    write_coef(2, 32768, d);
    bus.in_valid = 1'b1;
    bus.in_data  = DATA_W'(1000);
    tick();
    bus.in_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.out_data !== '0 || bus.sat_flag !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state: got data=%0d sat=%b expected 0/0", bus.out_data, bus.sat_flag);
    end
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_ready: got %b expected 1", bus.in_ready);
    end
    br = 0;
    for (int c = 0; c < LAT + 5; c++) begin
      tick();
      if (bus.out_valid) br++;
    end
    checks++;
    if (br !== 0) begin
      failures++;
      $display("FAIL midreset_no_out: got %0d outputs expected 0", br);
    end
    send_sample(1000, y, lat, br, ro);
    checks++;
    if (y !== 1000 || lat !== LAT) begin
      failures++;
      $display("FAIL midreset_identity: got data=%0d lat=%0d expected 1000/%0d", y, lat, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_scaling();
    test_recursion();
    test_overflow();
    test_write_guard();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
